// File: rtl/thread_state_mp_if.sv
// Bus bundle for thread_state_mp: write channels, read channels and status.
// Packed [ch][bit] layout places channel 0 in the least significant bits.
interface thread_state_mp_if #(
    parameter int N_THREADS = 16,
    parameter int STATE_W   = 4,
    parameter int N_WR      = 4,
    parameter int N_RD      = 4
);
    localparam int NUM_W = $clog2(N_THREADS);

    logic [N_WR-1:0]                wr_en;
    logic [N_WR-1:0][NUM_W-1:0]     wr_num;
    logic [N_WR-1:0][STATE_W-1:0]   wr_state;
    logic [N_RD-1:0][NUM_W-1:0]     rd_num;
    logic [N_RD-1:0][STATE_W-1:0]   rd_state;
    logic                           init_busy;
    logic [NUM_W:0]                 cnt;
    logic [N_WR-1:0]                err_ch;
    logic                           err;

    modport master (
        output wr_en, wr_num, wr_state, rd_num,
        input  rd_state, init_busy, cnt, err_ch, err
    );

    modport slave (
        input  wr_en, wr_num, wr_state, rd_num,
        output rd_state, init_busy, cnt, err_ch, err
    );
endinterface

// File: rtl/thread_state_mp.sv
// Multi-port thread state store: per-channel holding registers drained one
// commit per cycle by fixed priority, init sweep, bypassed registered reads.
module thread_state_mp #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
    parameter int STATE_W       = 4,
    parameter int N_WR          = 4,
    parameter int N_RD          = 4,
    parameter int INIT_STATE    = 0,
    parameter int COUNT_STATE   = 1,
    parameter int BYPASS        = 1
) (
    input  logic              clk,
    input  logic              rst,
    thread_state_mp_if.slave  bus
);
    localparam int NUM_W = N_THREADS_MSB + 1;
    localparam int CNT_W = NUM_W + 1;
    localparam logic [STATE_W-1:0] INIT_V  = STATE_W'(INIT_STATE);
    localparam logic [STATE_W-1:0] COUNT_V = STATE_W'(COUNT_STATE);
    localparam logic [NUM_W-1:0]   LAST_T  = NUM_W'(N_THREADS - 1);

    logic                          busy;
    logic [NUM_W-1:0]              sweep_ptr;
    logic [CNT_W-1:0]              cnt;
    logic [N_WR-1:0]               pend;
    logic [N_WR-1:0]               grant;
    logic [N_WR-1:0]               err_ch;
    logic [N_WR-1:0][NUM_W-1:0]    h_num;
    logic [N_WR-1:0][STATE_W-1:0]  h_state;

    logic                          we;
    logic [NUM_W-1:0]              waddr;
    logic [STATE_W-1:0]            wdata;
    logic [NUM_W-1:0]              cnum;
    logic [STATE_W-1:0]            cstate;
    logic [STATE_W-1:0]            old_val;

    // Lowest set pending bit wins; the sweep owns the write port while busy.
    always_comb begin
        grant = busy ? '0 : (pend & (~pend + N_WR'(1)));
    end

    always_comb begin
        cnum   = '0;
        cstate = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (grant[i]) begin
                cnum   = cnum | h_num[i];
                cstate = cstate | h_state[i];
            end
        end
    end

    always_comb begin
        we    = !rst && (busy || (|grant));
        waddr = busy ? sweep_ptr : cnum;
        wdata = busy ? INIT_V : cstate;
    end

    // Holding registers: a reload on the commit edge is a normal refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            err_ch  <= '0;
            h_num   <= '0;
            h_state <= '0;
        end else begin
            for (int i = 0; i < N_WR; i++) begin
                if (bus.wr_en[i]) begin
                    h_num[i]   <= bus.wr_num[i];
                    h_state[i] <= bus.wr_state[i];
                    pend[i]    <= 1'b1;
                    if (pend[i] && !grant[i])
                        err_ch[i] <= 1'b1;
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b1;
            sweep_ptr <= '0;
            cnt       <= '0;
        end else if (busy) begin
            // cnt was cleared by reset, so the sweep only ever adds.
            if (INIT_V == COUNT_V)
                cnt <= cnt + CNT_W'(1);
            if (sweep_ptr == LAST_T)
                busy <= 1'b0;
            else
                sweep_ptr <= sweep_ptr + NUM_W'(1);
        end else if (|grant) begin
            cnt <= cnt + CNT_W'(wdata == COUNT_V) - CNT_W'(old_val == COUNT_V);
        end
    end

    // One bank per read port plus one for the old-value lookup, all sharing
    // the single write port.
    for (genvar b = 0; b <= N_RD; b++) begin : g_bank
        logic [STATE_W-1:0] mem [N_THREADS];

        always_ff @(posedge clk) begin
            if (we)
                mem[waddr] <= wdata;
        end

        if (b < N_RD) begin : g_rd
            logic [STATE_W-1:0] q;

            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else if (BYPASS != 0 && we && waddr == bus.rd_num[b])
                    q <= wdata;
                else
                    q <= mem[bus.rd_num[b]];
            end

            assign bus.rd_state[b] = q;
        end else begin : g_old
            assign old_val = mem[waddr];
        end
    end

    assign bus.init_busy = busy;
    assign bus.cnt       = cnt;
    assign bus.err_ch    = err_ch;
    assign bus.err       = |err_ch;
endmodule

// File: tb/tb_thread_state_mp.sv
// Bench for thread_state_mp: directed scenarios plus random traffic against a
// per-cycle array model, with BYPASS=1 and BYPASS=0 instances in parallel.
module tb_thread_state_mp;
    localparam int NT   = 16;
    localparam int SW   = 4;
    localparam int NW   = 4;
    localparam int NR   = 4;
    localparam int NUMW = 4;
    localparam logic [SW-1:0] INIT_ST  = 4'd0;
    localparam logic [SW-1:0] COUNT_ST = 4'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thread_state_mp_if #(.N_THREADS(NT), .STATE_W(SW), .N_WR(NW), .N_RD(NR)) ifa ();
    thread_state_mp_if #(.N_THREADS(NT), .STATE_W(SW), .N_WR(NW), .N_RD(NR)) ifb ();

    assign ifb.wr_en    = ifa.wr_en;
    assign ifb.wr_num   = ifa.wr_num;
    assign ifb.wr_state = ifa.wr_state;
    assign ifb.rd_num   = ifa.rd_num;

    thread_state_mp #(.N_THREADS(NT), .STATE_W(SW), .N_WR(NW), .N_RD(NR),
                      .INIT_STATE(0), .COUNT_STATE(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    thread_state_mp #(.N_THREADS(NT), .STATE_W(SW), .N_WR(NW), .N_RD(NR),
                      .INIT_STATE(0), .COUNT_STATE(1), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: thread array, per-channel pending requests, read data.
    logic [SW-1:0]           m_mem [NT];
    logic [NW-1:0]           m_pend;
    logic [NW-1:0][NUMW-1:0] m_num;
    logic [NW-1:0][SW-1:0]   m_st;
    logic [NW-1:0]           m_err;
    logic                    m_busy;
    int                      m_ptr;
    logic [NR-1:0][SW-1:0]   m_rda;
    logic [NR-1:0][SW-1:0]   m_rdb;

    function automatic int model_cnt();
        int c = 0;
        for (int t = 0; t < NT; t++)
            if (m_mem[t] == COUNT_ST) c++;
        return c;
    endfunction

    function automatic void model_step();
        int g;
        logic w;
        int wa;
        logic [SW-1:0] wd;
        int rn;
        if (rst) begin
            m_pend = '0;
            m_err  = '0;
            m_busy = 1'b1;
            m_ptr  = 0;
            m_rda  = '0;
            m_rdb  = '0;
            return;
        end
        g  = -1;
        w  = 1'b0;
        wa = 0;
        wd = '0;
        if (m_busy) begin
            w = 1'b1; wa = m_ptr; wd = INIT_ST;
        end else begin
            for (int i = 0; i < NW; i++)
                if (m_pend[i] && g < 0) begin
                    g = i; w = 1'b1; wa = int'(m_num[i]); wd = m_st[i];
                end
        end
        for (int j = 0; j < NR; j++) begin
            rn = int'(ifa.rd_num[j]);
            m_rdb[j] = m_mem[rn];
            m_rda[j] = (w && wa == rn) ? wd : m_mem[rn];
        end
        for (int i = 0; i < NW; i++) begin
            if (ifa.wr_en[i]) begin
                if (m_pend[i] && g != i) m_err[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_num[i]  = ifa.wr_num[i];
                m_st[i]   = ifa.wr_state[i];
            end else if (g == i) begin
                m_pend[i] = 1'b0;
            end
        end
        if (w) m_mem[wa] = wd;
        if (m_busy) begin
            if (m_ptr == NT - 1) m_busy = 1'b0;
            else m_ptr++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        ifa.wr_en = '0;
    endtask

    task automatic test_reset();
        int busy_cycles;
        rst = 1'b1;
        idle();
        tick();
        n_checks++;
        if (ifa.init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_init_busy: got %0b want 1", ifa.init_busy); end
        n_checks++;
        if (ifa.cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", ifa.cnt); end
        n_checks++;
        if (ifa.err !== 1'b0 || ifa.err_ch !== 4'b0) begin n_fail++; $display("FAIL reset_err: got %0b/%b want 0/0000", ifa.err, ifa.err_ch); end
        n_checks++;
        if (ifa.rd_state !== 16'h0 || ifb.rd_state !== 16'h0) begin n_fail++; $display("FAIL reset_rd_state: got %h/%h want 0", ifa.rd_state, ifb.rd_state); end
        rst = 1'b0;
        busy_cycles = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!ifa.init_busy) break;
            busy_cycles++;
        end
        n_checks++;
        if (busy_cycles !== 16) begin n_fail++; $display("FAIL init_busy_len: got %0d cycles want 16", busy_cycles); end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < NR; j++) ifa.rd_num[j] = 4'(4 * k + j);
            tick();
            n_checks++;
            if (ifa.rd_state !== 16'h0 || ifb.rd_state !== 16'h0) begin n_fail++; $display("FAIL init_contents blk%0d: got %h/%h want 0", k, ifa.rd_state, ifb.rd_state); end
        end
        n_checks++;
        if (ifa.cnt !== 5'd0 || ifa.err !== 1'b0) begin n_fail++; $display("FAIL post_init_cnt_err: got %0d/%0b want 0/0", ifa.cnt, ifa.err); end
    endtask

    task automatic test_priority();
        ifa.rd_num[0] = 4'd3;
        ifa.wr_en = 4'b0101;
        ifa.wr_num[0] = 4'd3; ifa.wr_state[0] = 4'd1;
        ifa.wr_num[2] = 4'd3; ifa.wr_state[2] = 4'd2;
        tick();
        idle();
        tick();
        n_checks++;
        if (ifa.cnt !== 5'd1) begin n_fail++; $display("FAIL prio_cnt_first: got %0d want 1", ifa.cnt); end
        n_checks++;
        if (ifa.rd_state[0] !== 4'd1) begin n_fail++; $display("FAIL prio_bypass_first: got %0d want 1", ifa.rd_state[0]); end
        tick();
        n_checks++;
        if (ifa.cnt !== 5'd0) begin n_fail++; $display("FAIL prio_cnt_second: got %0d want 0", ifa.cnt); end
        tick();
        n_checks++;
        if (ifa.rd_state[0] !== 4'd2 || ifb.rd_state[0] !== 4'd2) begin n_fail++; $display("FAIL prio_final_thr3: got %0d/%0d want 2", ifa.rd_state[0], ifb.rd_state[0]); end
        n_checks++;
        if (ifa.err !== 1'b0) begin n_fail++; $display("FAIL prio_err: got %0b want 0", ifa.err); end
    endtask

    task automatic test_bypass();
        ifa.wr_en = 4'b0001; ifa.wr_num[0] = 4'd5; ifa.wr_state[0] = 4'd4;
        tick();
        idle();
        tick();
        tick();
        ifa.rd_num[0] = 4'd5;
        ifa.wr_en = 4'b0001; ifa.wr_num[0] = 4'd5; ifa.wr_state[0] = 4'd7;
        tick();
        idle();
        n_checks++;
        if (ifa.rd_state[0] !== 4'd4 || ifb.rd_state[0] !== 4'd4) begin n_fail++; $display("FAIL bypass_before: got %0d/%0d want 4", ifa.rd_state[0], ifb.rd_state[0]); end
        tick();
        n_checks++;
        if (ifa.rd_state[0] !== 4'd7) begin n_fail++; $display("FAIL bypass_on: got %0d want 7", ifa.rd_state[0]); end
        n_checks++;
        if (ifb.rd_state[0] !== 4'd4) begin n_fail++; $display("FAIL bypass_off_old: got %0d want 4", ifb.rd_state[0]); end
        tick();
        n_checks++;
        if (ifb.rd_state[0] !== 4'd7) begin n_fail++; $display("FAIL bypass_off_new: got %0d want 7", ifb.rd_state[0]); end
    endtask

    task automatic test_overflow();
        ifa.wr_en = 4'b0011;
        ifa.wr_num[0] = 4'd1; ifa.wr_state[0] = 4'd5;
        ifa.wr_num[1] = 4'd2; ifa.wr_state[1] = 4'd6;
        tick();
        ifa.wr_en = 4'b0010; ifa.wr_num[1] = 4'd2; ifa.wr_state[1] = 4'd9;
        tick();
        idle();
        n_checks++;
        if (ifa.err_ch !== 4'b0010 || ifa.err !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b/%0b want 0010/1", ifa.err_ch, ifa.err); end
        ifa.rd_num[1] = 4'd2;
        tick();
        tick();
        n_checks++;
        if (ifa.rd_state[1] !== 4'd9 || ifb.rd_state[1] !== 4'd9) begin n_fail++; $display("FAIL overflow_value: got %0d/%0d want 9", ifa.rd_state[1], ifb.rd_state[1]); end
        repeat (3) tick();
        n_checks++;
        if (ifa.err !== 1'b1 || ifb.err_ch !== 4'b0010) begin n_fail++; $display("FAIL overflow_sticky: got %0b/%b want 1/0010", ifa.err, ifb.err_ch); end
    endtask

    task automatic test_count_all();
        int waited;
        for (int t = 0; t < NT; t++) begin
            ifa.wr_en = 4'b0001; ifa.wr_num[0] = 4'(t); ifa.wr_state[0] = COUNT_ST;
            tick();
        end
        idle();
        tick();
        tick();
        n_checks++;
        if (ifa.cnt !== 5'd16) begin n_fail++; $display("FAIL count_all: got %0d want 16", ifa.cnt); end
        ifa.wr_en = 4'b1110;
        for (int i = 1; i < NW; i++) begin ifa.wr_num[i] = 4'(i - 1); ifa.wr_state[i] = 4'd2; end
        tick();
        idle();
        rst = 1'b1;
        tick();
        n_checks++;
        if (ifa.init_busy !== 1'b1 || ifa.cnt !== 5'd0 || ifa.err_ch !== 4'b0) begin n_fail++; $display("FAIL midreset_state: got busy %0b cnt %0d err %b want 1/0/0000", ifa.init_busy, ifa.cnt, ifa.err_ch); end
        rst = 1'b0;
        waited = 0;
        while (ifa.init_busy && waited < 40) begin tick(); waited++; end
        n_checks++;
        if (ifa.init_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_timeout: init_busy still %0b after %0d cycles", ifa.init_busy, waited); end
        for (int j = 0; j < 3; j++) ifa.rd_num[j] = 4'(j);
        repeat (3) tick();
        n_checks++;
        if (ifa.cnt !== 5'd0 || model_cnt() != 0) begin n_fail++; $display("FAIL midreset_cnt: got %0d want 0", ifa.cnt); end
        n_checks++;
        if (ifa.rd_state[2:0] !== 12'h0 || ifb.rd_state[2:0] !== 12'h0) begin n_fail++; $display("FAIL midreset_lost: got %h/%h want 0", ifa.rd_state[2:0], ifb.rd_state[2:0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NW; i++) begin
                ifa.wr_en[i]    = ($urandom_range(0, 3) == 0);
                ifa.wr_num[i]   = 4'($urandom_range(0, NT - 1));
                ifa.wr_state[i] = 4'($urandom_range(0, 3));
            end
            for (int j = 0; j < NR; j++) ifa.rd_num[j] = 4'($urandom_range(0, NT - 1));
            tick();
            n_checks++;
            if (ifa.rd_state !== m_rda) begin n_fail++; $display("FAIL rand_rd_bypass c%0d: got %h want %h", c, ifa.rd_state, m_rda); end
            n_checks++;
            if (ifb.rd_state !== m_rdb) begin n_fail++; $display("FAIL rand_rd_nobypass c%0d: got %h want %h", c, ifb.rd_state, m_rdb); end
            n_checks++;
            if (ifa.init_busy !== m_busy || ifa.err_ch !== m_err || ifa.err !== (|m_err)) begin
                n_fail++;
                $display("FAIL rand_status c%0d: got busy %0b err_ch %b want %0b %b", c, ifa.init_busy, ifa.err_ch, m_busy, m_err);
            end
            if (!m_busy) begin
                n_checks++;
                if (int'(ifa.cnt) != model_cnt()) begin n_fail++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, ifa.cnt, model_cnt()); end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        m_pend = '0; m_num = '0; m_st = '0; m_err = '0;
        m_busy = 1'b1; m_ptr = 0; m_rda = '0; m_rdb = '0;
        for (int t = 0; t < NT; t++) m_mem[t] = '0;
        ifa.wr_en = '0; ifa.wr_num = '0; ifa.wr_state = '0; ifa.rd_num = '0;
        test_reset();
        test_priority();
        test_bypass();
        test_overflow();
        test_count_all();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
